regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Debug read-out engine: the reader-side initiator for the processor register file's synchronous read port (1-cycle read latency).
- On a start pulse, walks all registers x0..x(NUM_REGS-1), captures each 32-bit word, and streams it out as little-endian bytes over a valid/ready byte interface feeding the UART transmitter.
- Gives the host a full register snapshot after each executed instruction.

Parameters:
- NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1.
- ADDR_W, 5, register address width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32, register width; must be a multiple of 8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- rd_addr  out  ADDR_W  register file read address, registered.
- rd_data  in  DATA_W  register file read data, valid one cycle after rd_addr is sampled.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid&&tx_ready at posedge.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE. busy, rd_addr, tx_data, tx_valid and done are all 0. Index, byte counter and shift register are cleared.
- A reset mid-dump aborts immediately. No partial-byte completion is required.
- States: IDLE, REQ, LATCH, SEND, FIN (plus CSUM under the option).
- IDLE: when start=1, set idx=0, rd_addr=0, busy=1, go to REQ.
- REQ: one cycle. The register file samples rd_addr at the end of this cycle. Go to LATCH.
- LATCH: one cycle. Load shift register with rd_data, byte_cnt=0, go to SEND.
- SEND:
  - tx_valid=1 and tx_data=shift[7:0].
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - On handshake: shift right by 8 and increment byte_cnt.
  - After handshake on byte DATA_W/8-1:
    - if idx==NUM_REGS-1, go to FIN (or CSUM);
    - else idx++, rd_addr=idx+1, go to REQ.
  - tx_valid deasserts in REQ and LATCH.
- FIN: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
- start asserted in the FIN cycle is ignored.
- Latency: start sampled at edge N gives tx_valid=1 in the cycle after edge N+2. Minimum per-register cost is 2+DATA_W/8 cycles (6 with defaults).
- Byte order: register 0 first; within a register, least-significant byte first. Total 4*NUM_REGS bytes (128 with defaults).
- x0 is read from the register file like any other address. No forced zero here.
- start while busy: no effect, no restart, no counter disturbance.
- Register file writes during a dump are permitted. Each word reflects the contents at its REQ cycle.
- idx is compared, never wrapped. No address beyond NUM_REGS-1 is ever driven.

Optional Feature:
- Macro REGFILE_DUMP_CHECKSUM_EN.
- Defined: an 8-bit running sum of all accepted dump bytes (mod 256) is kept, cleared on start and on reset.
  - After the last data byte, state CSUM sends one extra byte equal to the two's complement of the sum, under the same valid/ready rules. The sum of all bytes including the checksum is then 0x00 mod 256.
  - FIN follows the checksum handshake.
- Undefined: no CSUM state, no accumulator; FIN follows the last data byte directly.

Decomposition:
- Shared package regfile_dump_pkg:
  - state encoding constants (IDLE, REQ, LATCH, SEND, FIN, CSUM);
  - BYTES_PER_WORD = DATA_W/8;
  - checksum width constant.
- Natural sub-module word_serializer:
  - loads a DATA_W word and emits BYTES_PER_WORD bytes LSB-first over valid/ready;
  - signals last_byte_accepted;
  - the top FSM owns addressing, sequencing and checksum.

Test Plan:
- Reset then idle: all outputs 0. Registers preloaded with x[i]=i*0x01010101 and start pulsed with tx_ready=1 -> 128 bytes; byte k equals k/4; done pulses once after byte 127; busy low the next cycle.
- x15=0x12345678, others 0 -> bytes 60..63 are 78,56,34,12; all other bytes 00; first tx_valid appears in the 3rd cycle after the start edge.
- Backpressure: tx_ready low for 10 cycles during byte 5 -> tx_valid stays 1 and tx_data is constant; no byte is lost or duplicated; total count is still 128.
- start re-pulsed at byte 40 and again in the FIN cycle -> ignored; exactly one done; sequence unchanged.
- reset_n low for one cycle at byte 70 -> next cycle busy=0, tx_valid=0, rd_addr=0; a new start then produces a complete 128-byte dump from register 0.
- With REGFILE_DUMP_CHECKSUM_EN, all registers 0 -> 129th byte 0x00. With x1=0x00000001 only -> 129th byte 0xFF; done follows it.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register file dump engine: state encoding,
// byte-count helpers and checksum width (checksum used only with REGFILE_DUMP_CHECKSUM_EN).
package regfile_dump_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      LATCH = 3'd2,
      SEND  = 3'd3,
      FIN   = 3'd4,
      CSUM  = 3'd5
   } state_t;

   localparam int DATA_W_DEFAULT = 32;
   localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;
   localparam int CSUM_W         = 8;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

   // A one-byte word still needs a one-bit counter.
   function automatic int byte_cnt_width(input int data_w);
      return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
   endfunction

endpackage

// File: rtl/regfile_dump_word_serializer.sv
// Loads one register word and hands it out least-significant byte first
// over a valid/ready byte stream; flags the handshake on the final byte.
module word_serializer
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   input  logic              active,
   input  logic              ready,
   output logic [7:0]        byte_out,
   output logic              last_byte_accepted
);

   localparam int BPW   = bytes_per_word(DATA_W);
   localparam int CNT_W = byte_cnt_width(DATA_W);

   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  byte_cnt;
   logic              accept;

   assign accept             = active && ready;
   assign byte_out           = shift[7:0];
   assign last_byte_accepted = accept && (byte_cnt == CNT_W'(BPW - 1));

   // The shift register only moves on a handshake, so a stalled byte stays put.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift    <= '0;
         byte_cnt <= '0;
      end else if (load) begin
         shift    <= word;
         byte_cnt <= '0;
      end else if (accept) begin
         shift    <= shift >> 8;
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_dump.sv
// Register file snapshot engine: reads x0..x(NUM_REGS-1) and streams them as
// little-endian bytes. Define REGFILE_DUMP_CHECKSUM_EN to append a checksum byte.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state, next_state;
   logic [ADDR_W-1:0] idx;
   logic              ser_load;
   logic              ser_active;
   logic [7:0]        ser_byte;
   logic              last_accepted;
   logic              start_accept;

   assign start_accept = (state == IDLE) && start;
   assign ser_load     = (state == LATCH);
   assign ser_active   = (state == SEND);
   assign rd_addr      = idx;
   assign busy         = (state != IDLE);
   assign done         = (state == FIN);

   word_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk                (clk),
      .reset_n            (reset_n),
      .load               (ser_load),
      .word               (rd_data),
      .active             (ser_active),
      .ready              (tx_ready),
      .byte_out           (ser_byte),
      .last_byte_accepted (last_accepted)
   );

`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [CSUM_W-1:0] sum;

   // Running sum of every data byte the transmitter accepted in this dump.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum <= '0;
      end else if (start_accept) begin
         sum <= '0;
      end else if (ser_active && tx_ready) begin
         sum <= sum + ser_byte;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // idx doubles as the registered read address; it stops at the last register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (start_accept) begin
         idx <= '0;
      end else if (last_accepted && (idx != LAST_IDX)) begin
         idx <= idx + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      tx_valid   = 1'b0;
      tx_data    = 8'd0;
      case (state)
         IDLE:  if (start) next_state = REQ;
         REQ:   next_state = LATCH;
         LATCH: next_state = SEND;
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = ser_byte;
            if (last_accepted) begin
               if (idx == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  next_state = CSUM;
`else
                  next_state = FIN;
`endif
               end else begin
                  next_state = REQ;
               end
            end
         end
`ifdef REGFILE_DUMP_CHECKSUM_EN
         CSUM: begin
            tx_valid = 1'b1;
            tx_data  = 8'd0 - sum;
            if (tx_ready) next_state = FIN;
         end
`endif
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

endmodule
